aa_relu_lut_loader: RTL and testbench

- Runtime writer for the 256-entry AA-ReLU lookup table, which the activation unit reads as y0/y1 interpolation points (Q25.7).
- Accepts table words over a valid/ready stream, stores them, and checks the length and additive checksum.
- Serves two registered read ports, one for index and one for index+1, to the activation datapath once the table is valid.
- Replaces the static file-based table initialisation, so tables can be swapped between layers without resynthesis.

---
 rtl/aa_relu_lut_loader.sv | 113 +++++++++++
 tb/tb_aa_relu_lut_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aa_relu_lut_loader.sv
// Runtime loader for the AA-ReLU interpolation table: streamed fill with length and
// checksum tracking, plus two registered read ports serving the y0/y1 points.
module aa_relu_lut_loader #(
   parameter int N        = 32,
   parameter int LUT_SIZE = 256,
   parameter int AW       = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_start,
   input  logic          s_valid,
   input  logic [N-1:0]  s_data,
   input  logic          s_last,
   output logic          s_ready,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr0,
   input  logic [AW-1:0] rd_addr1,
   output logic [N-1:0]  rd_data0,
   output logic [N-1:0]  rd_data1,
   output logic          rd_valid,
   output logic          lut_ready,
   output logic          busy,
   output logic          err_len,
   output logic [AW:0]   load_count,
   output logic [N-1:0]  checksum
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY, ST_ERROR} state_t;

   state_t        r_state;
   logic [N-1:0]  r_table [LUT_SIZE];
   logic [AW:0]   r_load_count;
   logic [N-1:0]  r_checksum;
   logic          r_lut_ready;
   logic          r_busy;
   logic          r_err_len;
   logic          r_rd_valid;
   logic [N-1:0]  r_rd_data0;
   logic [N-1:0]  r_rd_data1;

   logic          w_beat;
   logic          w_final_slot;
   logic [AW-1:0] w_wr_addr;

   // NOTE: s_ready is combinational so a load_start pulse blocks a beat in its own cycle.
   assign s_ready      = (r_state == ST_LOAD) && !load_start;
   assign w_beat       = s_valid && s_ready;
   assign w_wr_addr    = r_load_count[AW-1:0];
   assign w_final_slot = (r_load_count == (AW+1)'(LUT_SIZE - 1));

   // Length check: the last slot must carry s_last, and s_last anywhere else is short.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_load_count <= '0;
         r_checksum   <= '0;
         r_lut_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_err_len    <= 1'b0;
      end else if (load_start) begin
         r_state      <= ST_LOAD;
         r_load_count <= '0;
         r_checksum   <= '0;
         r_lut_ready  <= 1'b0;
         r_busy       <= 1'b1;
         r_err_len    <= 1'b0;
      end else if (w_beat) begin
         r_load_count <= r_load_count + (AW+1)'(1);
         r_checksum   <= r_checksum + s_data;
         if (w_final_slot || s_last) begin
            r_busy <= 1'b0;
            if (w_final_slot && s_last) begin
               r_state     <= ST_READY;
               r_lut_ready <= 1'b1;
            end else begin
               r_state   <= ST_ERROR;
               r_err_len <= 1'b1;
            end
         end
      end
   end

   // NOTE: the table array has no reset; lut_ready alone says whether its contents mean anything.
   always_ff @(posedge clk) begin
      if (w_beat) begin
         r_table[w_wr_addr] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_data0 <= '0;
         r_rd_data1 <= '0;
      end else begin
         r_rd_valid <= rd_en && r_lut_ready;
         if (rd_en && r_lut_ready) begin
            r_rd_data0 <= r_table[rd_addr0];
            r_rd_data1 <= r_table[rd_addr1];
         end
      end
   end

   assign rd_data0   = r_rd_data0;
   assign rd_data1   = r_rd_data1;
   assign rd_valid   = r_rd_valid;
   assign lut_ready  = r_lut_ready;
   assign busy       = r_busy;
   assign err_len    = r_err_len;
   assign load_count = r_load_count;
   assign checksum   = r_checksum;

endmodule

// File: tb/tb_aa_relu_lut_loader.sv
// Randomized bench for aa_relu_lut_loader: a table-level reference model is compared
// against every output each cycle, with literal expectations at the key checkpoints.
module tb_aa_relu_lut_loader;

   localparam int N        = 32;
   localparam int LUT_SIZE = 256;
   localparam int AW       = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          load_start = 1'b0;
   logic          s_valid = 1'b0;
   logic [N-1:0]  s_data = '0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr0 = '0;
   logic [AW-1:0] rd_addr1 = '0;
   logic [N-1:0]  rd_data0;
   logic [N-1:0]  rd_data1;
   logic          rd_valid;
   logic          lut_ready;
   logic          busy;
   logic          err_len;
   logic [AW:0]   load_count;
   logic [N-1:0]  checksum;

   aa_relu_lut_loader #(.N(N), .LUT_SIZE(LUT_SIZE), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_valid(rd_valid),
      .lut_ready(lut_ready), .busy(busy), .err_len(err_len),
      .load_count(load_count), .checksum(checksum)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: table contents and load bookkeeping as plain variables.
   logic [N-1:0] m_table [LUT_SIZE];
   bit           m_loading = 0;
   bit           m_ready   = 0;
   bit           m_err     = 0;
   bit           m_rv      = 0;
   int           m_count   = 0;
   logic [N-1:0] m_sum     = '0;
   logic [N-1:0] m_d0      = '0;
   logic [N-1:0] m_d1      = '0;
   bit           chk_en    = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_loading = 0; m_ready = 0; m_err = 0; m_rv = 0;
         m_count = 0; m_sum = '0; m_d0 = '0; m_d1 = '0;
      end else begin
         m_rv = rd_en && m_ready;
         if (rd_en && m_ready) begin
            m_d0 = m_table[rd_addr0];
            m_d1 = m_table[rd_addr1];
         end
         if (load_start) begin
            m_loading = 1; m_ready = 0; m_err = 0; m_count = 0; m_sum = '0;
         end else if (s_valid && m_loading) begin
            m_table[m_count] = s_data;
            m_count++;
            m_sum += s_data;
            if (m_count == LUT_SIZE) begin
               m_loading = 0;
               if (s_last) m_ready = 1;
               else        m_err = 1;
            end else if (s_last) begin
               m_loading = 0;
               m_err = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      #3;
      if (chk_en) begin
         check("s_ready",    s_ready,    m_loading && !load_start);
         check("busy",       busy,       m_loading);
         check("lut_ready",  lut_ready,  m_ready);
         check("err_len",    err_len,    m_err);
         check("load_count", load_count, m_count);
         check("checksum",   checksum,   m_sum);
         check("rd_valid",   rd_valid,   m_rv);
         check("rd_data0",   rd_data0,   m_d0);
         check("rd_data1",   rd_data1,   m_d1);
      end
   end

   logic [N-1:0] vec [LUT_SIZE];

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         s_valid = 0; s_last = 0; load_start = 0; rd_en = 0;
      end
   endtask

   task automatic pulse_load();
      @(negedge clk);
      s_valid = 0; s_last = 0; load_start = 1;
      @(negedge clk);
      load_start = 0;
   endtask

   task automatic send_word(input logic [N-1:0] d, input bit last, input int gap_max,
                            input int budget, output bit ok);
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) begin
         @(negedge clk);
         s_valid = 0; s_last = 0; s_data = $urandom;
      end
      ok = 0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         s_valid = 1; s_data = d; s_last = last;
         #1 ok = s_ready;
      end
   endtask

   task automatic send_seq(input int n, input bit with_last, input int gap_max);
      bit ok;
      for (int i = 0; i < n; i++) begin
         send_word(vec[i], with_last && (i == n - 1), gap_max, 50, ok);
         check("beat_accept", ok, 1);
         if (!ok) break;
      end
   endtask

   task automatic random_reads(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rd_en    = ($urandom_range(3, 0) != 0);
         rd_addr0 = AW'($urandom_range(LUT_SIZE - 1, 0));
         rd_addr1 = ($urandom_range(4, 0) == 0) ? rd_addr0 : rd_addr0 + AW'(1);
      end
      @(negedge clk);
      rd_en = 0;
   endtask

   function automatic logic [N-1:0] vec_sum(input int n);
      logic [N-1:0] s = '0;
      for (int i = 0; i < n; i++) s += vec[i];
      return s;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_s_ready"},    s_ready,    0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_lut_ready"},  lut_ready,  0);
      check({tag, "_err_len"},    err_len,    0);
      check({tag, "_load_count"}, load_count, 0);
      check({tag, "_checksum"},   checksum,   0);
      check({tag, "_rd_valid"},   rd_valid,   0);
      check({tag, "_rd_data0"},   rd_data0,   0);
      check({tag, "_rd_data1"},   rd_data1,   0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit           ok;
      logic [N-1:0] exp_sum;
      logic [N-1:0] old7;

      #1 rst_n = 0;
      @(negedge clk); @(negedge clk);
      #1 check_all_zero("reset");
      chk_en = 1;
      @(negedge clk);
      rst_n = 1;
      idle(2);

      // 1: ramp table i*249 with s_last on the final word
      for (int i = 0; i < LUT_SIZE; i++) vec[i] = N'(i * 249);
      pulse_load();
      send_seq(LUT_SIZE, 1, 0);
      idle(2);
      #1;
      check("t1_lut_ready",  lut_ready,  1);
      check("t1_load_count", load_count, 256);
      check("t1_checksum",   checksum,   32'd8127360);
      check("t1_model_sum",  m_sum,      32'd8127360);
      check("t1_err_len",    err_len,    0);

      // 2: back-to-back reads with one-cycle latency
      @(negedge clk); rd_en = 1; rd_addr0 = 8'd10;  rd_addr1 = 8'd11;
      @(negedge clk); rd_addr0 = 8'd0;   rd_addr1 = 8'd1;
      #1 check("t2_d0_10", rd_data0, 2490);  check("t2_d1_11", rd_data1, 2739);
         check("t2_rv_a", rd_valid, 1);
      @(negedge clk); rd_addr0 = 8'd254; rd_addr1 = 8'd255;
      #1 check("t2_d0_0", rd_data0, 0);      check("t2_d1_1", rd_data1, 249);
         check("t2_rv_b", rd_valid, 1);
      @(negedge clk); rd_en = 0;
      #1 check("t2_d0_254", rd_data0, 63246); check("t2_d1_255", rd_data1, 63495);
         check("t2_rv_c", rd_valid, 1);
      @(negedge clk);
      #1 check("t2_rv_off", rd_valid, 0);
      random_reads(40);

      // 3: short table of 100 words
      for (int i = 0; i < LUT_SIZE; i++) vec[i] = $urandom;
      pulse_load();
      send_seq(100, 1, 2);
      idle(2);
      #1;
      check("t3_err_len",    err_len,    1);
      check("t3_lut_ready",  lut_ready,  0);
      check("t3_load_count", load_count, 100);
      check("t3_checksum",   checksum,   vec_sum(100));
      @(negedge clk); rd_en = 1; rd_addr0 = 8'd5; rd_addr1 = 8'd6;
      @(negedge clk); rd_en = 0;
      #1 check("t3_rv", rd_valid, 0);

      // 4: long table, 256 words without s_last
      for (int i = 0; i < LUT_SIZE; i++) vec[i] = $urandom;
      pulse_load();
      send_seq(LUT_SIZE, 0, 0);
      send_word(32'hDEAD_BEEF, 0, 0, 4, ok);
      check("t4_extra_rejected", ok, 0);
      idle(1);
      #1;
      check("t4_s_ready",    s_ready,    0);
      check("t4_err_len",    err_len,    1);
      check("t4_load_count", load_count, 256);
      check("t4_checksum",   checksum,   vec_sum(LUT_SIZE));

      // 5: abort at beat 50, then a full load of fresh words
      for (int i = 0; i < LUT_SIZE; i++) vec[i] = $urandom;
      pulse_load();
      send_seq(50, 0, 0);
      @(negedge clk); load_start = 1; s_valid = 1; s_data = vec[50]; s_last = 0;
      #1 check("t5_abort_s_ready", s_ready, 0);
      @(negedge clk); load_start = 0; s_valid = 0;
      #1 check("t5_count_cleared", load_count, 0);
         check("t5_busy", busy, 1);
      for (int i = 0; i < LUT_SIZE; i++) vec[i] = $urandom;
      exp_sum = vec_sum(LUT_SIZE);
      send_seq(LUT_SIZE, 1, 2);
      idle(2);
      #1;
      check("t5_lut_ready",  lut_ready,  1);
      check("t5_checksum",   checksum,   exp_sum);
      check("t5_load_count", load_count, 256);
      check("t5_err_len",    err_len,    0);
      random_reads(40);

      // Read issued with load_start returns old data; lut_ready falls the next cycle
      old7 = vec[7];
      @(negedge clk); load_start = 1; rd_en = 1; rd_addr0 = 8'd7; rd_addr1 = 8'd7;
      @(negedge clk); load_start = 0; rd_en = 0;
      #1 check("reload_rd_valid", rd_valid, 1);
         check("reload_rd_data0", rd_data0, old7);
         check("reload_rd_data1", rd_data1, old7);
         check("reload_lut_ready", lut_ready, 0);

      // 6: gappy load, reset after beat 128, then a clean full load
      for (int i = 0; i < LUT_SIZE; i++) vec[i] = $urandom;
      send_seq(128, 0, 3);
      @(negedge clk); rst_n = 0; s_valid = 0; s_last = 0;
      #1 check_all_zero("t6_reset");
      idle(2);
      @(negedge clk); rst_n = 1;
      @(negedge clk); rd_en = 1; rd_addr0 = 8'd1; rd_addr1 = 8'd2;
      @(negedge clk); rd_en = 0;
      #1 check("t6_idle_rv", rd_valid, 0);
      for (int i = 0; i < LUT_SIZE; i++) vec[i] = $urandom;
      exp_sum = vec_sum(LUT_SIZE);
      pulse_load();
      send_seq(LUT_SIZE, 1, 3);
      idle(2);
      #1;
      check("t6_lut_ready", lut_ready, 1);
      check("t6_checksum",  checksum,  exp_sum);
      random_reads(40);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
